decode_bundle_ctrl: RTL and testbench

// Sequences fetch bundles into the 8-wide decoder. Buffers up to DEPTH fetch bundles and presents the

---
 rtl/decode_bundle_ctrl_if.sv | 31 +++
 rtl/decode_bundle_ctrl.sv | 129 ++++++++++++
 tb/tb_decode_bundle_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_bundle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_bundle_ctrl_if
// Description : Fetch-to-decoder bundle handshake and decoder lane bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_bundle_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic                   fetch_valid_i;
    logic                   fetch_ready_o;
    logic [WIDTH-1:0]       fetch_mask_i;
    logic [WIDTH-1:0][31:0] fetch_instr_i;
    logic [WIDTH-1:0][63:0] fetch_pc_i;
    logic [WIDTH-1:0]       dec_valid_o;
    logic [WIDTH-1:0][31:0] dec_instr_o;
    logic [WIDTH-1:0][63:0] dec_pc_o;
    logic [CNT_W-1:0]       rn_accept_i;

    modport master (
        output fetch_valid_i, fetch_mask_i, fetch_instr_i, fetch_pc_i, rn_accept_i,
        input  fetch_ready_o, dec_valid_o, dec_instr_o, dec_pc_o
    );

    modport slave (
        input  fetch_valid_i, fetch_mask_i, fetch_instr_i, fetch_pc_i, rn_accept_i,
        output fetch_ready_o, dec_valid_o, dec_instr_o, dec_pc_o
    );
endinterface
`default_nettype wire

// File: rtl/decode_bundle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_bundle_ctrl
// Description : Buffers fetch bundles and presents the oldest unconsumed lanes,
//               packed from lane 0, splitting a bundle across partial accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_bundle_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush_i,
    decode_bundle_ctrl_if.slave    bus,
    output logic                   busy_o,
    output logic [15:0]            stall_cnt_o
);
    localparam int          PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          OCC_W  = $clog2(DEPTH + 1);
    localparam int          LANE_W = $clog2(WIDTH);
    localparam logic [31:0] C_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SPLIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [OCC_W-1:0]   r_occ;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_head_off;
    logic [15:0]        r_stall;

    logic [CNT_W-1:0]       r_cnt   [DEPTH];
    logic [WIDTH-1:0][31:0] r_instr [DEPTH];
    logic [WIDTH-1:0][63:0] r_pc    [DEPTH];

    logic               w_active;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_pop_cnt;
    logic [CNT_W-1:0]   w_head_n;
    logic [CNT_W-1:0]   w_rem;
    logic [CNT_W-1:0]   w_acc;
    logic [CNT_W-1:0]   w_head_off_nxt;
    logic [OCC_W-1:0]   w_occ_nxt;
    logic [WIDTH-1:0]   w_dec_valid;

    // Mask is contiguous from lane 0, so its popcount is the lane count.
    always_comb begin
        w_pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop_cnt = w_pop_cnt + CNT_W'(bus.fetch_mask_i[i]);
        end
    end

    // Entry contents are only meaningful while the FSM reports a valid head.
    assign w_active       = (r_state != IDLE);
    assign w_ready        = (r_occ < OCC_W'(DEPTH));
    assign w_push         = bus.fetch_valid_i && w_ready && !flush_i && (|bus.fetch_mask_i);
    assign w_head_n       = r_cnt[r_rd_ptr];
    assign w_rem          = w_head_n - r_head_off;
    assign w_acc          = (!w_active || flush_i) ? '0 :
                            ((bus.rn_accept_i < w_rem) ? bus.rn_accept_i : w_rem);
    assign w_pop          = w_active && !flush_i && ((r_head_off + w_acc) == w_head_n);
    assign w_head_off_nxt = w_pop ? '0 : (r_head_off + w_acc);
    assign w_occ_nxt      = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);

    for (genvar j = 0; j < WIDTH; j++) begin : g_lane
        logic [LANE_W-1:0] w_src;
        assign w_src                = r_head_off[LANE_W-1:0] + LANE_W'(j);
        assign w_dec_valid[j]       = w_active && (CNT_W'(j) < w_rem);
        assign bus.dec_instr_o[j]   = w_dec_valid[j] ? r_instr[r_rd_ptr][w_src] : C_NOP;
        assign bus.dec_pc_o[j]      = w_dec_valid[j] ? r_pc[r_rd_ptr][w_src]    : 64'h0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_cnt[r_wr_ptr]   <= w_pop_cnt;
            r_instr[r_wr_ptr] <= bus.fetch_instr_i;
            r_pc[r_wr_ptr]    <= bus.fetch_pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_occ      <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_head_off <= '0;
            r_stall    <= '0;
        end else begin
            if (flush_i) begin
                r_state    <= IDLE;
                r_occ      <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_head_off <= '0;
            end else begin
                r_occ      <= w_occ_nxt;
                r_head_off <= w_head_off_nxt;
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_occ_nxt == '0)
                    r_state <= IDLE;
                else if (w_head_off_nxt != '0)
                    r_state <= SPLIT;
                else
                    r_state <= ISSUE;
            end
            // Stall history survives flushes; only reset clears it.
            if ((|w_dec_valid) && (bus.rn_accept_i == '0) && !flush_i && (r_stall != 16'hFFFF))
                r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.fetch_ready_o = w_ready;
    assign bus.dec_valid_o   = w_dec_valid;
    assign busy_o            = w_active;
    assign stall_cnt_o       = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_decode_bundle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_bundle_ctrl
// Description : Scoreboard bench for decode_bundle_ctrl lane sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_bundle_ctrl;
    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        busy_o;
    logic [15:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bundle lane counts, head offset, expected lane stream
    int          m_q[$];
    int          m_head;
    int          m_stall;
    logic [31:0] sb_instr[$];
    logic [63:0] sb_pc[$];

    decode_bundle_ctrl_if #(.WIDTH(8), .CNT_W(4)) bif ();

    decode_bundle_ctrl #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .bus         (bif),
        .busy_o      (busy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bif.fetch_valid_i = 1'b0;
        bif.fetch_mask_i  = '0;
        bif.rn_accept_i   = '0;
        flush_i           = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bif.fetch_instr_i[i] = '0;
            bif.fetch_pc_i[i]    = '0;
        end
    endtask

    task automatic model_clear(input logic clr_stall);
        m_q.delete();
        sb_instr.delete();
        sb_pc.delete();
        m_head = 0;
        if (clr_stall) m_stall = 0;
    endtask

    // One clock cycle: drive, check presented state, consume scoreboard, advance model
    task automatic step(input logic fv, input logic [7:0] mask, input logic [63:0] pcb,
                        input int acc, input logic fl);
        int          rem;
        int          a;
        int          n;
        logic [7:0]  expv;
        logic        full;
        @(negedge clk);
        bif.fetch_valid_i = fv;
        bif.fetch_mask_i  = mask;
        bif.rn_accept_i   = 4'(acc);
        flush_i           = fl;
        for (int i = 0; i < 8; i++) begin
            bif.fetch_pc_i[i]    = pcb + 64'(4 * i);
            bif.fetch_instr_i[i] = (pcb[31:0] + 32'(4 * i)) ^ 32'h5A5A_0000;
        end
        #1;
        rem  = (m_q.size() > 0) ? (m_q[0] - m_head) : 0;
        expv = 8'((1 << rem) - 1);
        full = (m_q.size() >= 2);
        check("fetch_ready", 64'(bif.fetch_ready_o), 64'(!full));
        check("dec_valid",   64'(bif.dec_valid_o),   64'(expv));
        check("busy",        64'(busy_o),            64'(m_q.size() != 0));
        check("stall_cnt",   64'(stall_cnt_o),       64'(m_stall));
        if (rem < 8) begin
            check("nop_instr", 64'(bif.dec_instr_o[rem]), 64'h13);
            check("nop_pc",    bif.dec_pc_o[rem],          64'h0);
        end
        a = (acc < rem) ? acc : rem;
        if (fl) begin
            model_clear(1'b0);
        end else begin
            for (int j = 0; j < a; j++) begin
                if (sb_pc.size() == 0) begin
                    check("sb_underflow", 64'(j), 64'(-1));
                end else begin
                    check("lane_instr", 64'(bif.dec_instr_o[j]), 64'(sb_instr.pop_front()));
                    check("lane_pc",    bif.dec_pc_o[j],          sb_pc.pop_front());
                end
            end
            if (rem > 0 && acc == 0 && m_stall < 65535) m_stall++;
            if (rem > 0) begin
                m_head += a;
                if (m_head == m_q[0]) begin
                    void'(m_q.pop_front());
                    m_head = 0;
                end
            end
            if (fv && !full && mask != 0) begin
                n = $countones(mask);
                m_q.push_back(n);
                for (int i = 0; i < n; i++) begin
                    sb_pc.push_back(pcb + 64'(4 * i));
                    sb_instr.push_back((pcb[31:0] + 32'(4 * i)) ^ 32'h5A5A_0000);
                end
            end
        end
    endtask

    task automatic reset_now();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("rst_dec_valid", 64'(bif.dec_valid_o),   64'h0);
        check("rst_busy",      64'(busy_o),            64'h0);
        check("rst_ready",     64'(bif.fetch_ready_o), 64'h1);
        check("rst_stall",     64'(stall_cnt_o),       64'h0);
        model_clear(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nl;
        rst_n = 1'b0;
        drive_idle();
        model_clear(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("init_dec_valid", 64'(bif.dec_valid_o),   64'h0);
        check("init_busy",      64'(busy_o),            64'h0);
        check("init_ready",     64'(bif.fetch_ready_o), 64'h1);
        check("init_stall",     64'(stall_cnt_o),       64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full bundle, full accept
        step(1'b1, 8'hFF, 64'h1000, 8, 1'b0);
        step(1'b0, 8'h00, 64'h0,    8, 1'b0);
        step(1'b0, 8'h00, 64'h0,    0, 1'b0);

        // Six lanes consumed two at a time
        step(1'b1, 8'h3F, 64'h1000, 0, 1'b0);
        step(1'b0, 8'h00, 64'h0,    2, 1'b0);
        step(1'b0, 8'h00, 64'h0,    2, 1'b0);
        step(1'b0, 8'h00, 64'h0,    2, 1'b0);
        step(1'b0, 8'h00, 64'h0,    0, 1'b0);

        // Backpressure: third bundle held until space frees
        step(1'b1, 8'hFF, 64'h2000, 0, 1'b0);
        step(1'b1, 8'h0F, 64'h3000, 0, 1'b0);
        step(1'b1, 8'h03, 64'h4000, 0, 1'b0);
        step(1'b1, 8'h03, 64'h4000, 0, 1'b0);
        step(1'b1, 8'h03, 64'h4000, 8, 1'b0);
        step(1'b1, 8'h03, 64'h4000, 8, 1'b0);
        step(1'b0, 8'h00, 64'h0,    8, 1'b0);
        step(1'b0, 8'h00, 64'h0,    0, 1'b0);

        // Flush while split, with a push offered in the same cycle
        step(1'b1, 8'hFF, 64'h5000, 0, 1'b0);
        step(1'b0, 8'h00, 64'h0,    3, 1'b0);
        step(1'b1, 8'hFF, 64'h6000, 0, 1'b1);
        step(1'b0, 8'h00, 64'h0,    0, 1'b0);

        // Over-accept is clipped to the remaining lanes
        step(1'b1, 8'hFF, 64'h7000, 0, 1'b0);
        step(1'b1, 8'h0F, 64'h8000, 3, 1'b0);
        step(1'b0, 8'h00, 64'h0,    8, 1'b0);
        step(1'b0, 8'h00, 64'h0,    8, 1'b0);
        step(1'b0, 8'h00, 64'h0,    0, 1'b0);

        // Zero-mask offer is dropped
        step(1'b1, 8'h00, 64'hA000, 0, 1'b0);
        step(1'b0, 8'h00, 64'h0,    0, 1'b0);

        // Async reset in the middle of a split bundle
        step(1'b1, 8'hFF, 64'h9000, 0, 1'b0);
        step(1'b0, 8'h00, 64'h0,    2, 1'b0);
        reset_now();
        step(1'b0, 8'h00, 64'h0,    0, 1'b0);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            nl = $urandom_range(0, 8);
            step(1'($urandom_range(0, 1)), 8'((1 << nl) - 1),
                 {32'h0, $urandom} & 64'hFFFF_FFF0,
                 $urandom_range(0, 8), ($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
